xyolo_mac: RTL and testbench
============================

Name: xyolo_mac

Overview:
- Vector multiply-accumulate stage directly downstream of the weight/bias reader in the new Versat YOLO datapath.
- Each of nYOLOvect lanes multiplies a broadcast pixel stream by its own weight stream and adds its bias.
- Each lane requantizes with an arithmetic right shift, applies optional leaky activation and saturation, then emits one result per accumulation window.
- CPU-configured through the same valid/addr/wdata/wstrb request bus as the other xyolo units; sequenced by run/done.

Parameters:
- DATA_W, 16, signed operand width for pixel, weight, bias and result.
- ACC_W, 40, signed accumulator width.
- CNT_W, 16, iteration/period counter width.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- clear  in  1  async clear of configuration registers only
- run  in  1  start pulse; latches shadow config
- done  out  1  high when idle
- valid  in  1  config request
- addr  in  `XYOLO_MAC_ADDR_W  config register select
- wdata  in  `IO_ADDR_W  config data
- wstrb  in  1  write enable
- flow_in_pixel  in  DATA_W  broadcast pixel
- flow_in_weight  in  `nYOLOvect*DATA_W  per-lane weight; lane 0 in MSBs
- flow_in_bias  in  `nYOLOvect*DATA_W  per-lane bias; lane 0 in MSBs
- flow_out  out  `nYOLOvect*DATA_W  per-lane result; lane 0 in MSBs
- flow_out_valid  out  1  flow_out holds a new result this cycle

Behaviour:
- Config registers (`XYOLO_MAC_CONF_*`, written when valid&wstrb):
  - ITER (CNT_W): number of windows.
  - PER (CNT_W): samples per window.
  - DELAY (CNT_W): cycles from run to the first sample.
  - SHIFT (6b): output right shift.
  - BSHIFT (6b): bias left shift.
  - LEAKY (1b): leaky activation enable.
- All config registers reset/clear to 0; unknown addresses are ignored.
- On run while done=1, copy config to shadow registers. Compute uses shadows only, so the CPU may reprogram during a run. run while done=0 is ignored.
- FSM:
  - IDLE (done=1): on run, go to DELAY if DELAY>0, else ACC. If ITER=0 or PER=0, stay in IDLE with no output.
  - DELAY: count DELAY cycles, then ACC.
  - ACC: one sample per cycle. A per counter wraps at PER and the iteration counter increments. After the last sample of the last window, go to FLUSH.
  - FLUSH: 3 cycles to drain the pipeline, then IDLE.
- Pipeline, per lane:
  - S1: register pixel*weight as a 2*DATA_W signed product. Register a first-of-window flag alongside.
  - S2, first-of-window: acc = sext(bias)<<BSHIFT + product.
  - S2, otherwise: acc += product. Wraps modulo 2^ACC_W; no overflow detection.
  - S3: r = acc>>>SHIFT. If LEAKY and r<0, r = r>>>3. Saturate r to [-2^(DATA_W-1), 2^(DATA_W-1)-1] and register into flow_out.
- Sample timing:
  - Bias is sampled in the same cycle as the first sample of each window.
  - Bias is held stable by upstream across the whole window.
- Output timing:
  - flow_out_valid pulses for exactly 1 cycle, 3 cycles after the last sample of each window.
  - flow_out holds its value until the next pulse.
- done:
  - Goes low the cycle after an accepted run.
  - Returns high the cycle after the final flow_out_valid.
- Reset values:
  - done=1, flow_out=0, flow_out_valid=0.
  - All counters, accumulators and shadow registers 0.
  - Reset mid-operation aborts immediately; no partial output.
- clear affects the config registers only. A running job continues on its shadows.

Decomposition:
- Header xyolo_mac.vh holds `XYOLO_MAC_ADDR_W, the `XYOLO_MAC_CONF_* addresses, the FSM state encodings and the LEAKY shift constant (3).
- `nYOLOvect and `IO_ADDR_W come from xversat.vh.
- One sub-module, xyolo_mac_lane: S1–S3 datapath for one lane, generated nYOLOvect times. Control FSM and counters stay in the top.

Test Plan:
1. ITER=1, PER=4, DELAY=0, SHIFT=0, BSHIFT=0, bias=10, pixel=1..4, weight=2 every lane -> one flow_out_valid 3 cycles after 4th sample, every lane 30; done high next cycle.
2. ITER=2, PER=2, bias 0 then 100 (switching at window boundary), pixel=3, weight=-5 -> two pulses 2 cycles apart: -30, then 70.
3. Saturation and leaky, DATA_W=16:
   - products summing to 40000 with SHIFT=0 -> 32767.
   - acc=-800, SHIFT=2, LEAKY=1 -> -25.
   - LEAKY=0 with the same acc -> -200.
4. DELAY=5, PER=1, ITER=3 -> first sample taken exactly 5 cycles after run; 3 pulses on consecutive cycles.
5. ITER=0 or PER=0 with run -> done stays 1, no flow_out_valid. run pulsed mid-job -> ignored, results unchanged. Rewrite PER mid-job -> current job unaffected.
6. rst asserted in ACC -> done=1, flow_out=0 the same cycle. A subsequent run yields correct fresh results. clear mid-job -> job completes; next run with ITER=0 produces no output.

Source files
------------

// File: rtl/xyolo_mac_pkg.sv
// xyolo_mac_pkg: typed views of the xyolo_mac header constants
`include "xversat.vh"
`include "xyolo_mac.vh"
package xyolo_mac_pkg;
  localparam int NV = `nYOLOvect;
  localparam int IO_W = `IO_ADDR_W;
  localparam int MAC_ADDR_W = `XYOLO_MAC_ADDR_W;
  localparam int LEAKY_SH = `XYOLO_MAC_LEAKY_SH;
  localparam logic [MAC_ADDR_W-1:0] A_ITER = `XYOLO_MAC_CONF_ITER;
  localparam logic [MAC_ADDR_W-1:0] A_PER = `XYOLO_MAC_CONF_PER;
  localparam logic [MAC_ADDR_W-1:0] A_DELAY = `XYOLO_MAC_CONF_DELAY;
  localparam logic [MAC_ADDR_W-1:0] A_SHIFT = `XYOLO_MAC_CONF_SHIFT;
  localparam logic [MAC_ADDR_W-1:0] A_BSHIFT = `XYOLO_MAC_CONF_BSHIFT;
  localparam logic [MAC_ADDR_W-1:0] A_LEAKY = `XYOLO_MAC_CONF_LEAKY;
  typedef enum logic [1:0] {
    S_IDLE = `XYOLO_MAC_ST_IDLE,
    S_DELAY = `XYOLO_MAC_ST_DELAY,
    S_ACC = `XYOLO_MAC_ST_ACC,
    S_FLUSH = `XYOLO_MAC_ST_FLUSH
  } state_t;
endpackage

// File: rtl/xversat.vh
// xversat: global Versat datapath dimensions shared by the xyolo units
`ifndef XVERSAT_VH
`define XVERSAT_VH
`define nYOLOvect 4
`define IO_ADDR_W 32
`endif

// File: rtl/xyolo_mac.vh
// xyolo_mac: config addresses, FSM encodings and leaky shift for the MAC stage
`ifndef XYOLO_MAC_VH
`define XYOLO_MAC_VH
`define XYOLO_MAC_ADDR_W 3
`define XYOLO_MAC_CONF_ITER 3'd0
`define XYOLO_MAC_CONF_PER 3'd1
`define XYOLO_MAC_CONF_DELAY 3'd2
`define XYOLO_MAC_CONF_SHIFT 3'd3
`define XYOLO_MAC_CONF_BSHIFT 3'd4
`define XYOLO_MAC_CONF_LEAKY 3'd5
`define XYOLO_MAC_ST_IDLE 2'd0
`define XYOLO_MAC_ST_DELAY 2'd1
`define XYOLO_MAC_ST_ACC 2'd2
`define XYOLO_MAC_ST_FLUSH 2'd3
`define XYOLO_MAC_LEAKY_SH 3
`endif

// File: rtl/xyolo_mac_lane.sv
// xyolo_mac_lane: one lane of multiply, bias-seeded accumulate, requantize and saturate
`include "xyolo_mac.vh"
module xyolo_mac_lane
  import xyolo_mac_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int ACC_W = 40
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic signed [DATA_W-1:0] pixel,
  input  logic signed [DATA_W-1:0] weight,
  input  logic signed [DATA_W-1:0] bias,
  input  logic                     v1,
  input  logic                     f1,
  input  logic                     en,
  input  logic [5:0]               shift,
  input  logic [5:0]               bshift,
  input  logic                     leaky,
  output logic signed [DATA_W-1:0] flow_out
);
  logic signed [2*DATA_W-1:0] prod;
  logic signed [DATA_W-1:0] bias1, sat;
  logic signed [ACC_W-1:0] acc, seed, r0, r;
  logic fits;
  assign seed = ACC_W'(bias1) <<< bshift;
  assign r0 = acc >>> shift;
  assign r = (leaky && r0 < 0) ? r0 >>> LEAKY_SH : r0;
  // the value fits when every bit above the result sign bit matches it
  assign fits = &r[ACC_W-1:DATA_W-1] || !(|r[ACC_W-1:DATA_W-1]);
  assign sat = fits ? r[DATA_W-1:0] :
               r[ACC_W-1] ? {1'b1, {(DATA_W-1){1'b0}}} : {1'b0, {(DATA_W-1){1'b1}}};
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      prod <= '0;
      bias1 <= '0;
      acc <= '0;
      flow_out <= '0;
    end else begin
      prod <= (2*DATA_W)'(pixel) * (2*DATA_W)'(weight);
      bias1 <= bias;
      if (v1) acc <= (f1 ? seed : acc) + ACC_W'(prod);
      if (en) flow_out <= sat;
    end
endmodule

// File: rtl/xyolo_mac.sv
// xyolo_mac: config regs, run/done sequencer and nYOLOvect MAC lanes
`include "xversat.vh"
`include "xyolo_mac.vh"
module xyolo_mac
  import xyolo_mac_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int ACC_W = 40,
  parameter int CNT_W = 16
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               clear,
  input  logic                               run,
  output logic                               done,
  input  logic                               valid,
  input  logic [`XYOLO_MAC_ADDR_W-1:0]       addr,
  input  logic [`IO_ADDR_W-1:0]              wdata,
  input  logic                               wstrb,
  input  logic [DATA_W-1:0]                  flow_in_pixel,
  input  logic [`nYOLOvect*DATA_W-1:0]       flow_in_weight,
  input  logic [`nYOLOvect*DATA_W-1:0]       flow_in_bias,
  output logic [`nYOLOvect*DATA_W-1:0]       flow_out,
  output logic                               flow_out_valid
);
  logic [CNT_W-1:0] c_iter, c_per, c_delay, s_iter, s_per, s_delay, pcnt, icnt, cnt;
  logic [5:0] c_shift, c_bshift, s_shift, s_bshift;
  logic c_leaky, s_leaky, smp, last, v1, f1, l1, l2, unused_wdata;
  state_t state;
  assign unused_wdata = ^wdata;
  assign done = state == S_IDLE;
  assign smp = state == S_ACC;
  assign last = pcnt == s_per - CNT_W'(1);
  always_ff @(posedge clk or posedge rst or posedge clear)
    if (rst || clear) begin
      c_iter <= '0;
      c_per <= '0;
      c_delay <= '0;
      c_shift <= '0;
      c_bshift <= '0;
      c_leaky <= 1'b0;
    end else if (valid && wstrb) begin
      case (addr)
        A_ITER: c_iter <= wdata[CNT_W-1:0];
        A_PER: c_per <= wdata[CNT_W-1:0];
        A_DELAY: c_delay <= wdata[CNT_W-1:0];
        A_SHIFT: c_shift <= wdata[5:0];
        A_BSHIFT: c_bshift <= wdata[5:0];
        A_LEAKY: c_leaky <= wdata[0];
        default: ;
      endcase
    end
  // the run cycle counts as the first delay cycle, so DELAY<=1 starts sampling right away
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= S_IDLE;
      {s_iter, s_per, s_delay, s_shift, s_bshift, s_leaky} <= '0;
      {pcnt, icnt, cnt} <= '0;
      {v1, f1, l1, l2, flow_out_valid} <= '0;
    end else begin
      v1 <= smp;
      f1 <= smp && pcnt == '0;
      l1 <= smp && last;
      l2 <= l1;
      flow_out_valid <= l2;
      case (state)
        S_IDLE: if (run) begin
          {s_iter, s_per, s_delay, s_shift, s_bshift, s_leaky} <= {c_iter, c_per, c_delay, c_shift, c_bshift, c_leaky};
          pcnt <= '0;
          icnt <= '0;
          cnt <= CNT_W'(1);
          if (c_iter != '0 && c_per != '0) state <= c_delay > CNT_W'(1) ? S_DELAY : S_ACC;
        end
        S_DELAY: begin
          cnt <= cnt + CNT_W'(1);
          if (cnt == s_delay - CNT_W'(1)) state <= S_ACC;
        end
        S_ACC: begin
          pcnt <= last ? '0 : pcnt + CNT_W'(1);
          if (last) icnt <= icnt + CNT_W'(1);
          if (last && icnt == s_iter - CNT_W'(1)) begin
            state <= S_FLUSH;
            cnt <= '0;
          end
        end
        S_FLUSH: begin
          cnt <= cnt + CNT_W'(1);
          if (cnt == CNT_W'(2)) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  for (genvar i = 0; i < NV; i++) begin : g_lane
    xyolo_mac_lane #(.DATA_W(DATA_W), .ACC_W(ACC_W)) u_lane (
      .clk(clk),
      .rst(rst),
      .pixel(flow_in_pixel),
      .weight(flow_in_weight[(NV-1-i)*DATA_W +: DATA_W]),
      .bias(flow_in_bias[(NV-1-i)*DATA_W +: DATA_W]),
      .v1(v1),
      .f1(f1),
      .en(l2),
      .shift(s_shift),
      .bshift(s_bshift),
      .leaky(s_leaky),
      .flow_out(flow_out[(NV-1-i)*DATA_W +: DATA_W])
    );
  end
endmodule

// File: tb/tb_xyolo_mac.sv
// tb_xyolo_mac: directed jobs with a scoreboard of expected lane results and pulse cycles
module tb_xyolo_mac;
  import xyolo_mac_pkg::*;
  localparam int DW = 16;
  localparam int OW = NV*DW;
  typedef struct {logic [OW-1:0] d; int c;} exp_t;
  logic clk = 0, rst = 1, clear = 0, run = 0, valid = 0, wstrb = 0;
  logic [MAC_ADDR_W-1:0] addr = '0;
  logic [IO_W-1:0] wdata = '0;
  logic [DW-1:0] flow_in_pixel;
  logic [OW-1:0] flow_in_weight, flow_in_bias, flow_out;
  logic done, flow_out_valid;
  exp_t q[$];
  exp_t e;
  int cyc = 0, errors = 0, checks = 0;
  int pix_a[16];
  int wt_a[NV];
  int bias_a[4][NV];
  int exp_a[4][NV];

  xyolo_mac dut (
    .clk(clk), .rst(rst), .clear(clear), .run(run), .done(done),
    .valid(valid), .addr(addr), .wdata(wdata), .wstrb(wstrb),
    .flow_in_pixel(flow_in_pixel), .flow_in_weight(flow_in_weight), .flow_in_bias(flow_in_bias),
    .flow_out(flow_out), .flow_out_valid(flow_out_valid)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [OW-1:0] act, input logic [OW-1:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h required %h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  always @(negedge clk) if (flow_out_valid) begin
    if (q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL unexpected_valid: got flow_out_valid=1 flow_out=%h required no pulse (cycle %0d)", flow_out, cyc);
    end else begin
      e = q.pop_front();
      chk("flow_out", flow_out, e.d);
      chk("valid_cycle", OW'(cyc), OW'(e.c));
    end
  end

  function automatic logic [OW-1:0] pack(input int w);
    logic [OW-1:0] v;
    for (int l = 0; l < NV; l++) v[(NV-1-l)*DW +: DW] = DW'(exp_a[w][l]);
    return v;
  endfunction

  task automatic idle_inputs();
    flow_in_pixel = DW'(99);
    flow_in_weight = {NV{16'd99}};
    flow_in_bias = {NV{16'd99}};
  endtask

  task automatic wr(input logic [MAC_ADDR_W-1:0] a, input int d);
    valid = 1; wstrb = 1; addr = a; wdata = IO_W'(d);
    @(posedge clk); #1;
    valid = 0; wstrb = 0;
  endtask

  task automatic null_run();
    run = 1;
    @(posedge clk); #1;
    run = 0;
    repeat (4) begin
      chk("done_stays_idle", OW'(done), OW'(1));
      @(posedge clk); #1;
    end
  endtask

  task automatic job(input int iter, input int per, input int dly, input int sh, input int bsh,
                     input int lk, input int mid, input int abort_at);
    int t0, n;
    exp_t ne;
    wr(A_ITER, iter); wr(A_PER, per); wr(A_DELAY, dly);
    wr(A_SHIFT, sh); wr(A_BSHIFT, bsh); wr(A_LEAKY, lk);
    run = 1; t0 = cyc;
    @(posedge clk); #1;
    run = 0;
    chk("done_low_after_run", OW'(done), '0);
    while (cyc < t0 + (dly > 1 ? dly : 1)) begin @(posedge clk); #1; end
    n = 0;
    for (int w = 0; w < iter; w++)
      for (int s = 0; s < per; s++) begin
        if (n == abort_at) begin
          rst = 1; #1;
          chk("abort_done", OW'(done), OW'(1));
          chk("abort_flow_out", flow_out, '0);
          @(posedge clk); #1;
          rst = 0;
          q.delete();
          idle_inputs();
          return;
        end
        flow_in_pixel = DW'(pix_a[n]);
        for (int l = 0; l < NV; l++) begin
          flow_in_weight[(NV-1-l)*DW +: DW] = DW'(wt_a[l]);
          flow_in_bias[(NV-1-l)*DW +: DW] = DW'(bias_a[w][l]);
        end
        if (n == 1 && mid == 1) run = 1;
        if (n == 1 && mid == 2) begin valid = 1; wstrb = 1; addr = A_PER; wdata = IO_W'(7); end
        if (n == 1 && mid == 3) clear = 1;
        if (s == per - 1) begin ne.d = pack(w); ne.c = cyc + 3; q.push_back(ne); end
        @(posedge clk); #1;
        run = 0; valid = 0; wstrb = 0; clear = 0;
        n++;
      end
    idle_inputs();
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("done_low_at_last_pulse", OW'(done), '0);
    @(posedge clk); #1;
    chk("done_high_after_pulse", OW'(done), OW'(1));
    chk("scoreboard_drained", OW'(q.size()), '0);
  endtask

  initial begin
    #200000;
    errors++;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    idle_inputs();
    repeat (2) @(posedge clk);
    #1;
    chk("reset_done", OW'(done), OW'(1));
    chk("reset_flow_out", flow_out, '0);
    chk("reset_valid", OW'(flow_out_valid), '0);
    rst = 0;
    @(posedge clk); #1;
    for (int i = 0; i < 4; i++) pix_a[i] = i + 1;
    wt_a = '{2, 2, 2, 2}; bias_a[0] = '{10, 10, 10, 10}; exp_a[0] = '{30, 30, 30, 30};
    job(1, 4, 0, 0, 0, 0, 0, -1);
    wt_a = '{1, 2, 3, 4}; bias_a[0] = '{10, 20, -5, 0}; exp_a[0] = '{50, 100, 10, 40};
    job(1, 4, 0, 0, 2, 0, 1, -1);
    job(1, 4, 0, 0, 2, 0, 2, -1);
    for (int i = 0; i < 6; i++) pix_a[i] = 3;
    wt_a = '{-5, -5, -5, -5};
    bias_a[0] = '{0, 0, 0, 0}; bias_a[1] = '{100, 100, 100, 100}; bias_a[2] = '{0, 0, 0, 0};
    exp_a[0] = '{-30, -30, -30, -30}; exp_a[1] = '{70, 70, 70, 70}; exp_a[2] = '{-30, -30, -30, -30};
    job(2, 2, 0, 0, 0, 0, 0, -1);
    pix_a[0] = 200; pix_a[1] = 200;
    wt_a = '{100, -100, 50, 0}; bias_a[0] = '{0, 0, 0, 0}; exp_a[0] = '{32767, -32768, 20000, 0};
    job(1, 2, 0, 0, 0, 0, 0, -1);
    pix_a[0] = -40;
    wt_a = '{20, -20, 1, 0}; exp_a[0] = '{-25, 200, -2, 0};
    job(1, 1, 0, 2, 0, 1, 0, -1);
    exp_a[0] = '{-200, 200, -10, 0};
    job(1, 1, 0, 2, 0, 0, 0, -1);
    pix_a[0] = 1; pix_a[1] = 2; pix_a[2] = 3;
    wt_a = '{1, 2, 3, 4};
    bias_a[0] = '{1, 1, 1, 1}; bias_a[1] = '{-1, -1, -1, -1}; bias_a[2] = '{0, 0, 0, 0};
    exp_a[0] = '{2, 3, 4, 5}; exp_a[1] = '{1, 3, 5, 7}; exp_a[2] = '{3, 6, 9, 12};
    job(3, 1, 5, 0, 0, 0, 0, -1);
    wr(A_ITER, 0); wr(A_PER, 2);
    null_run();
    wr(A_ITER, 2); wr(A_PER, 0);
    null_run();
    for (int i = 0; i < 4; i++) pix_a[i] = i + 1;
    wt_a = '{2, 2, 2, 2}; bias_a[0] = '{10, 10, 10, 10}; exp_a[0] = '{30, 30, 30, 30};
    job(1, 4, 0, 0, 0, 0, 3, -1);
    null_run();
    for (int i = 0; i < 6; i++) pix_a[i] = 3;
    wt_a = '{-5, -5, -5, -5};
    bias_a[0] = '{0, 0, 0, 0}; bias_a[1] = '{100, 100, 100, 100}; bias_a[2] = '{0, 0, 0, 0};
    exp_a[0] = '{-30, -30, -30, -30}; exp_a[1] = '{70, 70, 70, 70}; exp_a[2] = '{-30, -30, -30, -30};
    job(3, 2, 0, 0, 0, 0, 0, 5);
    repeat (6) @(posedge clk);
    #1;
    chk("no_output_after_abort", OW'(q.size()), '0);
    for (int i = 0; i < 4; i++) pix_a[i] = i + 1;
    wt_a = '{2, 2, 2, 2}; bias_a[0] = '{10, 10, 10, 10}; exp_a[0] = '{30, 30, 30, 30};
    job(1, 4, 0, 0, 0, 0, 0, -1);
    repeat (4) @(posedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
